sprite_line_scheduler: RTL
==========================

// Module: sprite_line_scheduler
// PURPOSE
// - Owns the object table (ship, aliens, rockets, explosions) and decides, per pixel, which single element drives pixel_graphics.
// - During each line it pre-evaluates the NEXT scanline: scans the table and builds a short list of sprites that overlap that line.
// - During active video it picks the highest-priority listed sprite covering x.
// - Drives element_type/x/y and sprite_color into the renderer, one pixel_clk after x/y.
// PARAMETERS
// - NUM_OBJ     32   object table entries; index 0 = highest priority
// - LINE_SLOTS  8    max sprites per scanline
// - SPRITE_W    32   sprite width in pixels
// - SPRITE_H    32   sprite height in lines
// - SCREEN_H    480  visible lines; line counter wraps 479 -> 0
// PORTS
// - pixel_clk      in   1   the single clock; all logic is on its rising edge
// - reset          in   1   synchronous, active-high
// - x, y           in   10  current pixel coordinates from the VGA timing generator
// - line_start     in   1   one-cycle pulse at start of horizontal blank of line y
// - obj_we         in   1   object table write strobe
// - obj_addr       in   5   entry index (clog2 NUM_OBJ)
// - obj_en         in   1   entry enable
// - obj_type       in   3   element type code
// - obj_x, obj_y   in   10  top-left corner
// - obj_color      in   2   sprite_color code
// - element_valid  out  1   a sprite covers the registered pixel
// - element_type   out  3
// - element_x, element_y  out  10
// - sprite_color   out  2
// - line_overflow  out  1   sticky until next line_start: > LINE_SLOTS hits on the evaluated line
// - eval_late      out  1   one-cycle pulse: line_start arrived before evaluation finished
// BEHAVIOUR
// - Reset: all entries disabled; both slot banks empty; FSM = IDLE.
// - Reset: element_valid=0 and element_type/x/y/sprite_color=0; line_overflow=0; eval_late=0.
// - Reset mid-evaluation aborts the scan at once.
// - Table writes land at the next edge.
// - A write and a scan of the same index in the same cycle: the scan uses the old value.
// - Entries not yet scanned see new data this line; entries already scanned see it on the next line.
// - FSM IDLE: wait for line_start.
// - On line_start:
//   - swap banks (display <= eval);
//   - clear the eval bank and line_overflow;
//   - eval_line = (y == SCREEN_H-1) ? 0 : y+1;
//   - idx = 0; go to EVAL.
// - FSM EVAL: one entry per cycle. Hit = obj_en && (eval_line - obj_y) < SPRITE_H.
//   - The subtraction is 10-bit unsigned, so obj_y > eval_line never hits.
//   - A hit is appended to the next free slot, in index order.
//   - A hit with all slots full sets line_overflow and goes to DONE.
//   - idx == NUM_OBJ-1 -> DONE.
// - FSM DONE: wait for line_start, then act as in IDLE.
// - line_start while in EVAL:
//   - pulse eval_late;
//   - swap in the partial list;
//   - restart EVAL for the new line.
// - Display path:
//   - slot s hits when valid_s && (x - slot_x_s) < SPRITE_W (10-bit unsigned);
//   - the lowest-index hitting slot wins, even if its pixel is transparent;
//   - output is registered, latency exactly 1 pixel_clk;
//   - no hit: element_valid=0, other outputs 0.
// - element_y = the winning obj_y; the renderer derives the row as y - element_y.
// - Evaluation needs NUM_OBJ+2 cycles, which must be <= the horizontal blank length (160 at 640x480).
// STRUCTURE
// - Shared package space_inv_pkg holds:
//   - element type codes (SHIP=0, ALIEN0..2=1..3, EXPLOSION=4, ROCKET=5);
//   - SCREEN_W/SCREEN_H;
//   - the obj_t struct {en,type,x,y,color};
//   - the FSM state enum.
// - Sub-module sprite_slot_select: the combinational compare plus priority encoder over LINE_SLOTS; returns the hit flag and winning index.
// - The object table, FSM and double-buffered slot banks stay in this module.
// TESTING
// - Reset with line_start pulses, table empty -> element_valid=0 at every x; line_overflow=0.
// - Entry 3 {en,ALIEN1,x=100,y=50,col=2}:
//   - eval for line 60, x=100..131 -> valid=1, type=2, x=100, y=50, color=2 one cycle later;
//   - x=99 and x=132 -> valid=0.
// - Entries 1 and 7 overlap at x=200 on line 40 -> entry 1 is presented; disable entry 1 -> entry 7 from the next line.
// - Ten enabled entries, all on line 10 -> the first 8 by index are listed, line_overflow=1; cleared at the next line_start.
// - Wrap: obj_y=470, line_start with y=479 -> eval_line=0, no hit; obj_y=0 -> hit.
// - line_start pulses 20 cycles apart -> eval_late pulses; the partial list is displayed; a later normal line recovers.
// - reset asserted mid-EVAL -> all outputs 0 next cycle; FSM IDLE.

Source files
------------

// File: rtl/space_inv_pkg.sv
// Shared types for the space-invaders video pipeline: element codes, screen size,
// object-table entry layout, scheduler states and the wrap-around span test.
package space_inv_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [2:0] {
        ELEM_SHIP      = 3'd0,
        ELEM_ALIEN0    = 3'd1,
        ELEM_ALIEN1    = 3'd2,
        ELEM_ALIEN2    = 3'd3,
        ELEM_EXPLOSION = 3'd4,
        ELEM_ROCKET    = 3'd5
    } elem_type_e;

    typedef struct packed {
        logic       en;
        logic [2:0] etype;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] color;
    } obj_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] etype;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] color;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    // 10-bit unsigned difference, so a base beyond pos wraps high and never matches.
    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] base,
                                     input logic [9:0] len);
        logic [9:0] diff;
        diff = pos - base;
        return (diff < len);
    endfunction

endpackage

// File: rtl/sprite_slot_select.sv
// Horizontal compare of every display slot against x and a priority encoder
// that returns the lowest-index covering slot.
module sprite_slot_select
    import space_inv_pkg::*;
#(
    parameter int LINE_SLOTS = 8,
    parameter int SPRITE_W   = 32,
    parameter int IDX_W      = $clog2(LINE_SLOTS)
) (
    input  logic [9:0]       x,
    input  slot_t            slots [LINE_SLOTS],
    output logic             hit,
    output logic [IDX_W-1:0] win_idx
);

    localparam logic [9:0] SPAN_W = 10'(SPRITE_W);

    // Walk from the last slot down so the lowest-index hit is the one left standing.
    always_comb begin
        hit     = 1'b0;
        win_idx = '0;
        for (int s = LINE_SLOTS - 1; s >= 0; s--) begin
            if (slots[s].valid && in_span(x, slots[s].x, SPAN_W)) begin
                hit     = 1'b1;
                win_idx = IDX_W'(s);
            end else begin
                hit     = hit;
                win_idx = win_idx;
            end
        end
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Object table plus per-line sprite scheduler: evaluates the next scanline into one
// slot bank while the other bank drives the registered per-pixel element outputs.
module sprite_line_scheduler
    import space_inv_pkg::*;
#(
    parameter int NUM_OBJ    = 32,
    parameter int LINE_SLOTS = 8,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32
) (
    input  logic                       pixel_clk,
    input  logic                       reset,
    input  logic [9:0]                 x,
    input  logic [9:0]                 y,
    input  logic                       line_start,
    input  logic                       obj_we,
    input  logic [$clog2(NUM_OBJ)-1:0] obj_addr,
    input  logic                       obj_en,
    input  logic [2:0]                 obj_type,
    input  logic [9:0]                 obj_x,
    input  logic [9:0]                 obj_y,
    input  logic [1:0]                 obj_color,
    output logic                       element_valid,
    output logic [2:0]                 element_type,
    output logic [9:0]                 element_x,
    output logic [9:0]                 element_y,
    output logic [1:0]                 sprite_color,
    output logic                       line_overflow,
    output logic                       eval_late
);

    localparam int ADDR_W = $clog2(NUM_OBJ);
    localparam int SLOT_W = $clog2(LINE_SLOTS);
    localparam int CNT_W  = $clog2(LINE_SLOTS + 1);
    localparam logic [9:0]        SPAN_H    = 10'(SPRITE_H);
    localparam logic [9:0]        LAST_LINE = 10'(SCREEN_H - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_OBJ - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(LINE_SLOTS);

    obj_t              table_q     [NUM_OBJ];
    obj_t              table_d     [NUM_OBJ];
    slot_t             eval_bank_q [LINE_SLOTS];
    slot_t             eval_bank_d [LINE_SLOTS];
    slot_t             disp_bank_q [LINE_SLOTS];
    slot_t             disp_bank_d [LINE_SLOTS];
    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [9:0]        eval_line_q, eval_line_d;
    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic              line_overflow_q, line_overflow_d;
    logic              eval_late_q, eval_late_d;
    slot_t             element_q, element_d;

    obj_t              scan_obj_s;
    logic              scan_hit_s;
    logic              disp_hit_s;
    logic [SLOT_W-1:0] disp_win_s;

    // The scan reads the registered table, so a same-cycle write is seen one line later.
    assign scan_obj_s = table_q[idx_q];
    assign scan_hit_s = scan_obj_s.en && in_span(eval_line_q, scan_obj_s.y, SPAN_H);

    // Table update, bank swap on line_start and the one-entry-per-cycle evaluation.
    always_comb begin
        table_d         = table_q;
        eval_bank_d     = eval_bank_q;
        disp_bank_d     = disp_bank_q;
        state_d         = state_q;
        idx_d           = idx_q;
        eval_line_d     = eval_line_q;
        slot_cnt_d      = slot_cnt_q;
        line_overflow_d = line_overflow_q;
        eval_late_d     = 1'b0;

        if (obj_we) begin
            table_d[obj_addr] = '{en: obj_en, etype: obj_type, x: obj_x, y: obj_y,
                                  color: obj_color};
        end else begin
            table_d = table_q;
        end

        if (line_start) begin
            eval_late_d = (state_q == ST_EVAL);
            disp_bank_d = eval_bank_q;
            for (int s = 0; s < LINE_SLOTS; s++) begin
                eval_bank_d[s] = '0;
            end
            line_overflow_d = 1'b0;
            eval_line_d     = (y == LAST_LINE) ? 10'd0 : (y + 10'd1);
            idx_d           = '0;
            slot_cnt_d      = '0;
            state_d         = ST_EVAL;
        end else begin
            case (state_q)
                ST_EVAL: begin
                    if (scan_hit_s && (slot_cnt_q == FULL_CNT)) begin
                        line_overflow_d = 1'b1;
                        state_d         = ST_DONE;
                    end else begin
                        if (scan_hit_s) begin
                            eval_bank_d[slot_cnt_q[SLOT_W-1:0]] =
                                '{valid: 1'b1, etype: scan_obj_s.etype, x: scan_obj_s.x,
                                  y: scan_obj_s.y, color: scan_obj_s.color};
                            slot_cnt_d = slot_cnt_q + CNT_W'(1);
                        end else begin
                            slot_cnt_d = slot_cnt_q;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + ADDR_W'(1);
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    sprite_slot_select #(
        .LINE_SLOTS (LINE_SLOTS),
        .SPRITE_W   (SPRITE_W),
        .IDX_W      (SLOT_W)
    ) u_slot_select (
        .x       (x),
        .slots   (disp_bank_q),
        .hit     (disp_hit_s),
        .win_idx (disp_win_s)
    );

    // A covering slot wins even where its pixel is transparent; the renderer decides that.
    always_comb begin
        element_d = '0;
        if (disp_hit_s) begin
            element_d = disp_bank_q[disp_win_s];
        end else begin
            element_d = '0;
        end
    end

    // All state, including the output register, with synchronous reset.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                table_q[i] <= '0;
            end
            for (int s = 0; s < LINE_SLOTS; s++) begin
                eval_bank_q[s] <= '0;
                disp_bank_q[s] <= '0;
            end
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            eval_line_q     <= '0;
            slot_cnt_q      <= '0;
            line_overflow_q <= 1'b0;
            eval_late_q     <= 1'b0;
            element_q       <= '0;
        end else begin
            table_q         <= table_d;
            eval_bank_q     <= eval_bank_d;
            disp_bank_q     <= disp_bank_d;
            state_q         <= state_d;
            idx_q           <= idx_d;
            eval_line_q     <= eval_line_d;
            slot_cnt_q      <= slot_cnt_d;
            line_overflow_q <= line_overflow_d;
            eval_late_q     <= eval_late_d;
            element_q       <= element_d;
        end
    end

    assign element_valid = element_q.valid;
    assign element_type  = element_q.etype;
    assign element_x     = element_q.x;
    assign element_y     = element_q.y;
    assign sprite_color  = element_q.color;
    assign line_overflow = line_overflow_q;
    assign eval_late     = eval_late_q;

endmodule
